lcd_char_writer: RTL and testbench
==================================

Name: lcd_char_writer

Overview:
- Consumes the 8-bit ASCII character and valid strobe produced by the keypad decode path (0x30–0x39 plus CHK).
- Drives an HD44780-compatible 16x2 character LCD over an 8-bit write-only bus.
- Performs the power-on init sequence, then writes each new character at the cursor, wrapping line 1 → line 2 → line 1.
- Sits between the keypad decoder and the board LCD pins.

Parameters:
- POWERON_CYC, 750000, idle cycles after reset before the first command (15 ms at 50 MHz).
- SETUP_CYC, 4, cycles RS/DATA are stable before E rises.
- E_PULSE_CYC, 12, cycles E is held high.
- CMD_WAIT_CYC, 2500, cycles after E falls for normal commands/data (50 us).
- CLEAR_WAIT_CYC, 82000, cycles after E falls for the clear command 0x01 (1.64 ms).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- char_data  in  8  ASCII byte from the keypad decoder.
- char_valid  in  1  level valid (CHK); a 0→1 transition requests one write.
- clr_req  in  1  single-cycle pulse: clear display, cursor home.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_RW  out  1  tied 0 (write only).
- LCD_DATA  out  8  LCD data bus.
- ready  out  1  init complete and no bus cycle in progress.
- ovf  out  1  one-cycle pulse when a request is dropped.

Behaviour:
- Reset (async, immediate) state:
  - LCD_E = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 0x00, ready = 0, ovf = 0.
  - FSM = PWRON, timer = 0, cursor = 0, holding register empty, char_valid edge register = 0.
- Reset asserted mid-cycle aborts the current cycle: E drops in the same instant and the full init sequence reruns after release.
- Edge detect: req = char_valid & ~char_valid_q. Exactly one write per rising edge; holding char_valid high produces no repeats.
- Holding register: one entry holding data + kind (CHAR or CLEAR).
  - Loaded on req or clr_req when empty.
  - If req and clr_req arrive in the same cycle, CLEAR wins and the char is dropped with an ovf pulse.
  - A request arriving while the entry is full is dropped and pulses ovf. A new CLEAR overwrites a pending CHAR, with an ovf pulse.
  - The entry is freed on the cycle the FSM leaves IDLE with it.
- FSM states: PWRON → INIT → IDLE → (ADDR) → BUS → IDLE.
  - PWRON: count POWERON_CYC cycles, then go to INIT with init index 0.
  - INIT: issue commands 0x38, 0x0C, 0x01, 0x06 in order, each as a full bus cycle. After 0x06: cursor = 0, go to IDLE, ready = 1.
  - IDLE: ready = 1 only when the holding entry is empty or is being accepted this cycle. On a pending entry, go to ADDR or BUS.
  - Bus cycle (sub-module):
    - SETUP_CYC cycles with E = 0 and RS/DATA driven.
    - E_PULSE_CYC cycles with E = 1.
    - Wait CMD_WAIT_CYC cycles (CLEAR_WAIT_CYC if the command is 0x01) with E = 0.
    - RS/DATA held stable for the entire cycle.
- CHAR write:
  - cursor 0–15 → address 0x80 + cursor; cursor 16–31 → address 0xC0 + (cursor − 16).
  - If cursor == 16, or cursor == 0 after a wrap, first issue the address command (0xC0 or 0x80, RS = 0) in ADDR, then write data with RS = 1.
  - After each data write, cursor = (cursor + 1) mod 32.
  - A write at cursor 31 wraps to 0 and sets the wrap flag; the next char issues 0x80.
- CLEAR: issue 0x01 (RS = 0) with CLEAR_WAIT_CYC, then cursor = 0 and clear the wrap flag.
- ready = 0 throughout PWRON, INIT, ADDR, and BUS.
- Timer width: clog2(max parameter + 1); the counter saturates and does not wrap.

Decomposition:
- Package lcd_pkg:
  - Command constants: CMD_FUNC_SET 0x38, CMD_DISP_ON 0x0C, CMD_CLEAR 0x01, CMD_ENTRY 0x06, ADDR_LINE1 0x80, ADDR_LINE2 0xC0.
  - FSM state enum.
  - Request-kind enum.
- Sub-module lcd_bus_cycle:
  - Inputs: start, rs, data, long_wait.
  - Outputs: LCD_E, LCD_RS, LCD_DATA, done.
  - Owns the SETUP / E_PULSE / WAIT timer.
- Top module owns init sequencing, edge detect, holding register, and cursor.

Test Plan:
(bench uses POWERON_CYC=20, SETUP_CYC=2, E_PULSE_CYC=3, CMD_WAIT_CYC=5, CLEAR_WAIT_CYC=10)
- Reset release → after 20 cycles, four E pulses with DATA 0x38, 0x0C, 0x01, 0x06 and RS = 0; the gap after 0x01 is 10 cycles; then ready = 1.
- char_data = 0x35, char_valid 0→1 held 50 cycles → exactly one E pulse with RS = 1, DATA = 0x35, stable across the full pulse; ovf = 0.
- Write 16 chars 0x30..0x39, 0x30..0x35, then 0x37 → before the 17th data write, a command 0xC0 with RS = 0 is issued.
- Write 32 chars, then 0x31 → command 0x80 precedes the 0x31 data write.
- While BUS is busy: char edge fills the entry, a second char edge pulses ovf; a simultaneous clr_req and char edge yields 0x01 only, with an ovf pulse.
- Assert rst during the E-high phase → LCD_E = 0 immediately; after release, the full init sequence repeats and cursor = 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 character writer.
// Command bytes, controller/bus-phase state encodings and small helpers.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] ADDR_LINE1   = 8'h80;
    localparam logic [7:0] ADDR_LINE2   = 8'hC0;

    typedef enum logic [2:0] {
        ST_PWRON,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_BUS
    } lcd_state_t;

    typedef enum logic {
        REQ_CHAR,
        REQ_CLEAR
    } req_kind_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } bus_phase_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Power-on command list, issued in index order.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_CLEAR;
            default: cmd = CMD_ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write cycle: setup with E low, E high pulse, then the
// post-write wait. RS/DATA are latched on start and held throughout.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = 4,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int TIMER_W        = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA,
    output logic       done
);

    bus_phase_t         phase;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_inc;
    logic [TIMER_W-1:0] wait_last;
    logic               long_q;

    always_comb begin
        timer_inc = (timer == '1) ? timer : timer + TIMER_W'(1);
        wait_last = long_q ? TIMER_W'(CLEAR_WAIT_CYC - 1) : TIMER_W'(CMD_WAIT_CYC - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= PH_IDLE;
            timer    <= '0;
            long_q   <= 1'b0;
            LCD_E    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        LCD_RS   <= rs;
                        LCD_DATA <= data;
                        long_q   <= long_wait;
                        timer    <= '0;
                        phase    <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    if (timer == TIMER_W'(SETUP_CYC - 1)) begin
                        LCD_E <= 1'b1;
                        timer <= '0;
                        phase <= PH_PULSE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                PH_PULSE: begin
                    if (timer == TIMER_W'(E_PULSE_CYC - 1)) begin
                        LCD_E <= 1'b0;
                        timer <= '0;
                        phase <= PH_WAIT;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                PH_WAIT: begin
                    if (timer == wait_last) begin
                        done  <= 1'b1;
                        phase <= PH_IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_writer.sv
// Keypad-to-LCD character writer: power-on init, one-entry request buffer,
// cursor tracking with line 1 -> line 2 -> line 1 wrapping.
module lcd_char_writer
    import lcd_pkg::*;
#(
    parameter int POWERON_CYC    = 750000,
    parameter int SETUP_CYC      = 4,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    input  logic       clr_req,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       ready,
    output logic       ovf
);

    localparam int MAX_CYC = max_int(max_int(max_int(POWERON_CYC, SETUP_CYC),
                                             max_int(E_PULSE_CYC, CMD_WAIT_CYC)),
                                     CLEAR_WAIT_CYC);
    localparam int TIMER_W = $clog2(MAX_CYC + 1);

    lcd_state_t         state;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         init_idx;
    logic               started;
    logic [4:0]         cursor;
    logic               wrapped;
    logic               cv_q;
    logic               hold_full;
    req_kind_t          hold_kind;
    logic [7:0]         hold_data;
    req_kind_t          cur_kind;
    logic [7:0]         char_q;
    logic               cur_rs;
    logic [7:0]         cur_data;

    logic req;
    logic accept;
    logic entry_busy;
    logic need_addr;
    logic bus_start;
    logic bus_done;
    logic long_wait;

    always_comb begin
        req        = char_valid & ~cv_q;
        accept     = (state == ST_IDLE) && hold_full;
        entry_busy = hold_full && !accept;
        need_addr  = (cursor == 5'd16) || ((cursor == 5'd0) && wrapped);
        bus_start  = ((state == ST_INIT) || (state == ST_ADDR) || (state == ST_BUS)) && !started;
        long_wait  = !cur_rs && (cur_data == CMD_CLEAR);
    end

    assign LCD_RW = 1'b0;

    lcd_bus_cycle #(
        .SETUP_CYC      (SETUP_CYC),
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
        .TIMER_W        (TIMER_W)
    ) u_bus (
        .clk       (clk),
        .rst       (rst),
        .start     (bus_start),
        .rs        (cur_rs),
        .data      (cur_data),
        .long_wait (long_wait),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_DATA  (LCD_DATA),
        .done      (bus_done)
    );

    // A CLEAR always claims the entry; anything it displaces is reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cv_q      <= 1'b0;
            hold_full <= 1'b0;
            hold_kind <= REQ_CHAR;
            hold_data <= 8'h00;
            ovf       <= 1'b0;
        end else begin
            cv_q <= char_valid;
            ovf  <= 1'b0;
            if (clr_req) begin
                hold_full <= 1'b1;
                hold_kind <= REQ_CLEAR;
                hold_data <= CMD_CLEAR;
                ovf       <= req | entry_busy;
            end else if (req) begin
                if (entry_busy) begin
                    ovf <= 1'b1;
                end else begin
                    hold_full <= 1'b1;
                    hold_kind <= REQ_CHAR;
                    hold_data <= char_data;
                end
            end else if (accept) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_PWRON;
            timer    <= '0;
            init_idx <= 2'd0;
            started  <= 1'b0;
            cursor   <= 5'd0;
            wrapped  <= 1'b0;
            cur_kind <= REQ_CHAR;
            char_q   <= 8'h00;
            cur_rs   <= 1'b0;
            cur_data <= 8'h00;
            ready    <= 1'b0;
        end else begin
            if (bus_start) started <= 1'b1;
            case (state)
                ST_PWRON: begin
                    if (timer == TIMER_W'(POWERON_CYC - 1)) begin
                        state    <= ST_INIT;
                        init_idx <= 2'd0;
                        started  <= 1'b0;
                        cur_rs   <= 1'b0;
                        cur_data <= init_cmd(2'd0);
                    end else if (timer != '1) begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_INIT: begin
                    if (bus_done) begin
                        if (init_idx == 2'd3) begin
                            state   <= ST_IDLE;
                            ready   <= 1'b1;
                            cursor  <= 5'd0;
                            wrapped <= 1'b0;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                            cur_data <= init_cmd(init_idx + 2'd1);
                            started  <= 1'b0;
                        end
                    end
                end
                ST_IDLE: begin
                    if (hold_full) begin
                        ready    <= 1'b0;
                        started  <= 1'b0;
                        cur_kind <= hold_kind;
                        char_q   <= hold_data;
                        if (hold_kind == REQ_CLEAR) begin
                            cur_rs   <= 1'b0;
                            cur_data <= CMD_CLEAR;
                            state    <= ST_BUS;
                        end else if (need_addr) begin
                            cur_rs   <= 1'b0;
                            cur_data <= cursor[4] ? ADDR_LINE2 : ADDR_LINE1;
                            state    <= ST_ADDR;
                        end else begin
                            cur_rs   <= 1'b1;
                            cur_data <= hold_data;
                            state    <= ST_BUS;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus_done) begin
                        started  <= 1'b0;
                        cur_rs   <= 1'b1;
                        cur_data <= char_q;
                        state    <= ST_BUS;
                        if (cursor == 5'd0) wrapped <= 1'b0;
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        if (cur_kind == REQ_CLEAR) begin
                            cursor  <= 5'd0;
                            wrapped <= 1'b0;
                        end else begin
                            cursor <= cursor + 5'd1;
                            if (cursor == 5'd31) wrapped <= 1'b1;
                        end
                    end
                end
                default: state <= ST_PWRON;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer: a negedge monitor captures every E pulse,
// a vector table drives character/clear requests, hand sequences cover overflow and reset.
module tb_lcd_char_writer;

    localparam int P_PWR   = 20;
    localparam int P_SETUP = 2;
    localparam int P_PULSE = 3;
    localparam int P_WAIT  = 5;
    localparam int P_CLR   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_data = 8'h00;
    logic       char_valid = 1'b0;
    logic       clr_req = 1'b0;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
    logic       ready;
    logic       ovf;

    lcd_char_writer #(
        .POWERON_CYC    (P_PWR),
        .SETUP_CYC      (P_SETUP),
        .E_PULSE_CYC    (P_PULSE),
        .CMD_WAIT_CYC   (P_WAIT),
        .CLEAR_WAIT_CYC (P_CLR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_data  (char_data),
        .char_valid (char_valid),
        .clr_req    (clr_req),
        .LCD_E      (LCD_E),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_DATA   (LCD_DATA),
        .ready      (ready),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } pulse_t;

    typedef struct {
        logic       clr;
        logic [7:0] ch;
        int         hold;
        logic       addr_en;
        logic [7:0] addr;
    } vec_t;

    pulse_t     cap_q[$];
    logic [8:0] exp_q[$];
    vec_t       vecs[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         ovf_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // E-pulse monitor: setup/hold/width of every pulse, and E-low gap before it.
    logic       prev_e = 1'b0;
    logic [8:0] prev_bus = 9'h000;
    logic [8:0] pulse_bus = 9'h000;
    int         stable_cnt = 0;
    int         hi_cnt = 0;
    int         lo_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_e     = 1'b0;
            hi_cnt     = 0;
            lo_cnt     = 0;
            stable_cnt = 0;
            prev_bus   = {LCD_RS, LCD_DATA};
        end else begin
            if ({LCD_RS, LCD_DATA} != prev_bus) stable_cnt = 1;
            else stable_cnt++;
            prev_bus = {LCD_RS, LCD_DATA};
            if (ovf) ovf_cnt++;
            if (LCD_E && !prev_e) begin
                check("setup_stable", 32'(stable_cnt > P_SETUP), 32'd1);
                check("ready_while_busy", 32'(ready), 32'd0);
                cap_q.push_back('{LCD_RS, LCD_DATA, lo_cnt});
                pulse_bus = prev_bus;
                hi_cnt = 1;
            end else if (LCD_E) begin
                check("bus_hold", 32'({LCD_RS, LCD_DATA}), 32'(pulse_bus));
                hi_cnt++;
            end else if (prev_e) begin
                check("e_width", 32'(hi_cnt), 32'(P_PULSE));
                check("rw_low", 32'(LCD_RW), 32'd0);
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
            prev_e = LCD_E;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] ch, input int hold);
        step();
        char_data  = ch;
        char_valid = 1'b1;
        repeat (hold) step();
        char_valid = 1'b0;
    endtask

    task automatic send_clear();
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    // Idle means ready held for 3 samples; a full entry in IDLE shows ready for only 1.
    task automatic wait_idle(input string name);
        int hi;
        int cyc;
        hi  = 0;
        cyc = 0;
        repeat (3) step();
        while (hi < 3 && cyc < 3000) begin
            @(negedge clk);
            hi = ready ? hi + 1 : 0;
            cyc++;
        end
        check({name, " idle_timeout"}, 32'(hi >= 3), 32'd1);
        step();
    endtask

    task automatic check_pulses(input string name);
        check({name, " pulse_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check({name, " pulse_rs_data"}, 32'({cap_q[i].rs, cap_q[i].data}), 32'(exp_q[i]));
        cap_q.delete();
        exp_q.delete();
    endtask

    // E-low gap before each init pulse = preceding wait + next setup + handshake.
    task automatic check_init(input string name);
        exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006};
        if (cap_q.size() >= 4) begin
            check({name, " poweron_gap_min"}, 32'(cap_q[0].gap >= P_PWR + P_SETUP), 32'd1);
            check({name, " cmd_gap_min"}, 32'(cap_q[1].gap >= P_WAIT + P_SETUP), 32'd1);
            check({name, " cmd_gap_equal"}, 32'(cap_q[2].gap), 32'(cap_q[1].gap));
            check({name, " clear_gap_extra"}, 32'(cap_q[3].gap - cap_q[2].gap), 32'(P_CLR - P_WAIT));
        end
        check_pulses(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;

        vecs.push_back('{1'b1, 8'h00, 1, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 8'h35, 50, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 8'h00, 1, 1'b0, 8'h00});
        for (int i = 0; i < 16; i++) vecs.push_back('{1'b0, 8'h30 + 8'(i % 10), 1, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 8'h37, 1, 1'b1, 8'hC0});
        for (int i = 17; i < 32; i++) vecs.push_back('{1'b0, 8'h30 + 8'(i % 10), 1, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 8'h31, 1, 1'b1, 8'h80});
        vecs.push_back('{1'b0, 8'h32, 1, 1'b0, 8'h00});

        // Reset state
        repeat (3) step();
        check("rst LCD_E", 32'(LCD_E), 32'd0);
        check("rst LCD_RS", 32'(LCD_RS), 32'd0);
        check("rst LCD_RW", 32'(LCD_RW), 32'd0);
        check("rst LCD_DATA", 32'(LCD_DATA), 32'h00);
        check("rst ready", 32'(ready), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        wait_idle("init");
        check_init("init");
        check("init ready", 32'(ready), 32'd1);

        for (int v = 0; v < vecs.size(); v++) begin
            ovf_cnt = 0;
            if (vecs[v].clr) send_clear();
            else send_char(vecs[v].ch, vecs[v].hold);
            wait_idle("vec");
            if (vecs[v].clr) begin
                exp_q.push_back({1'b0, 8'h01});
            end else begin
                if (vecs[v].addr_en) exp_q.push_back({1'b0, vecs[v].addr});
                exp_q.push_back({1'b1, vecs[v].ch});
            end
            check_pulses($sformatf("vec%0d", v));
            check($sformatf("vec%0d ovf", v), 32'(ovf_cnt), 32'd0);
        end

        // Entry fills while busy; a further char edge is dropped
        ovf_cnt = 0;
        send_char(8'h41, 1);
        repeat (3) step();
        send_char(8'h42, 1);
        repeat (2) step();
        send_char(8'h43, 1);
        wait_idle("ovf_char");
        exp_q = '{{1'b1, 8'h41}, {1'b1, 8'h42}};
        check_pulses("ovf_char");
        check("ovf_char ovf_pulses", 32'(ovf_cnt), 32'd1);

        // Simultaneous clear and char edge: clear wins
        ovf_cnt = 0;
        send_char(8'h44, 1);
        repeat (3) step();
        step();
        char_data  = 8'h45;
        char_valid = 1'b1;
        clr_req    = 1'b1;
        step();
        char_valid = 1'b0;
        clr_req    = 1'b0;
        wait_idle("clr_char");
        exp_q = '{{1'b1, 8'h44}, {1'b0, 8'h01}};
        check_pulses("clr_char");
        check("clr_char ovf_pulses", 32'(ovf_cnt), 32'd1);

        // Clear overwrites a pending char
        ovf_cnt = 0;
        send_char(8'h46, 1);
        repeat (3) step();
        send_char(8'h47, 1);
        repeat (2) step();
        send_clear();
        wait_idle("clr_over");
        exp_q = '{{1'b1, 8'h46}, {1'b0, 8'h01}};
        check_pulses("clr_over");
        check("clr_over ovf_pulses", 32'(ovf_cnt), 32'd1);

        // Move cursor to 16, then reset in the middle of the next E pulse
        for (int i = 0; i < 16; i++) begin
            send_char(8'h30 + 8'(i % 10), 1);
            wait_idle("fill16");
            exp_q.push_back({1'b1, 8'h30 + 8'(i % 10)});
        end
        check_pulses("fill16");
        send_char(8'h39, 1);
        cyc = 0;
        while (!LCD_E && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst e_seen", 32'(LCD_E), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst LCD_E", 32'(LCD_E), 32'd0);
        check("midrst ready", 32'(ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        cap_q.delete();
        rst = 1'b0;
        wait_idle("reinit");
        check_init("reinit");

        // Cursor back at 0: plain data write, no address command
        ovf_cnt = 0;
        send_char(8'h33, 1);
        wait_idle("post_rst");
        exp_q = '{{1'b1, 8'h33}};
        check_pulses("post_rst");
        check("post_rst ovf", 32'(ovf_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
